// File: rtl/adc_parallel_responder.sv
// Emulates an 8-bit parallel-output ADC (CONVST/CS/RD/BUSY/D) sampling a digital source.
// Optional sticky overrun flag OVR is built when ADC_RESP_OVERRUN_EN is defined.
module adc_parallel_responder #(
   parameter int DATA_W      = 8,
   parameter int CONV_CYCLES = 16
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              CONVST,
   input  logic              CS,
   input  logic              RD,
   input  logic [DATA_W-1:0] sample_in,
   output logic [DATA_W-1:0] D,
   output logic              D_OE,
   output logic              BUSY,
   output logic              DRDY
`ifdef ADC_RESP_OVERRUN_EN
   ,
   output logic              OVR
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_READY   = 2'd2
   } state_t;

   localparam logic [7:0] CNT_INIT = 8'(CONV_CYCLES - 1);

   state_t              state_r, state_s;
   logic [7:0]          cnt_r, cnt_s;
   logic [DATA_W-1:0]   hold_r, hold_s;
   logic [DATA_W-1:0]   result_r, result_s;
   logic [DATA_W-1:0]   d_r, d_s;
   logic                busy_r, busy_s;
   logic                drdy_r, drdy_s;
   logic                d_oe_r;
   logic                convst_q_r, rd_q_r;
   logic                start_s, rd_rise_s, rd_act_s;

   assign start_s   = convst_q_r & ~CONVST;
   assign rd_rise_s = ~rd_q_r & RD;
   assign rd_act_s  = ~CS & ~RD;

   // Next-state logic for the conversion FSM and the read-data path.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      hold_s   = hold_r;
      result_s = result_r;
      busy_s   = busy_r;
      drdy_s   = drdy_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               hold_s  = sample_in;
               cnt_s   = CNT_INIT;
               busy_s  = 1'b1;
               state_s = ST_CONVERT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CONVERT: begin
            // A start seen here is ignored; the running conversion is never restarted.
            if (cnt_r == 8'd0) begin
               result_s = hold_r;
               busy_s   = 1'b0;
               drdy_s   = 1'b1;
               state_s  = ST_READY;
            end else begin
               cnt_s = cnt_r - 8'd1;
            end
         end
         ST_READY: begin
            if (start_s) begin
               hold_s  = sample_in;
               cnt_s   = CNT_INIT;
               busy_s  = 1'b1;
               state_s = ST_CONVERT;
            end else if (rd_rise_s && !CS) begin
               drdy_s  = 1'b0;
               state_s = ST_IDLE;
            end else begin
               state_s = ST_READY;
            end
         end
         default: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
            cnt_s   = 8'd0;
         end
      endcase
      if (rd_act_s) begin
         d_s = result_r;
      end else begin
         d_s = d_r;
      end
   end

   // State, counter, data and strobe-history registers.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_r    <= ST_IDLE;
         cnt_r      <= 8'd0;
         hold_r     <= {DATA_W{1'b0}};
         result_r   <= {DATA_W{1'b0}};
         d_r        <= {DATA_W{1'b0}};
         d_oe_r     <= 1'b0;
         busy_r     <= 1'b0;
         drdy_r     <= 1'b0;
         convst_q_r <= 1'b1;
         rd_q_r     <= 1'b1;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         hold_r     <= hold_s;
         result_r   <= result_s;
         d_r        <= d_s;
         d_oe_r     <= rd_act_s;
         busy_r     <= busy_s;
         drdy_r     <= drdy_s;
         convst_q_r <= CONVST;
         rd_q_r     <= RD;
      end
   end

   assign D    = d_r;
   assign D_OE = d_oe_r;
   assign BUSY = busy_r;
   assign DRDY = drdy_r;

`ifdef ADC_RESP_OVERRUN_EN
   logic ovr_r, ovr_evt_s;

   // Overrun: start during a conversion, or a completion that overwrites an unread result.
   always_comb begin
      if (state_r == ST_CONVERT) begin
         ovr_evt_s = start_s | ((cnt_r == 8'd0) & drdy_r);
      end else begin
         ovr_evt_s = 1'b0;
      end
   end

   // Sticky overrun flag, cleared only by reset.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         ovr_r <= 1'b0;
      end else begin
         ovr_r <= ovr_r | ovr_evt_s;
      end
   end

   assign OVR = ovr_r;
`endif

endmodule

// File: tb/tb_adc_parallel_responder.sv
// Table-driven bench for adc_parallel_responder plus hand-written reset and read/complete sequences.
module tb_adc_parallel_responder;

   logic       Clk, Rst, CONVST, CS, RD;
   logic [7:0] sample_in, D;
   logic       D_OE, BUSY, DRDY;
`ifdef ADC_RESP_OVERRUN_EN
   logic       OVR;
`endif

   int total = 0;
   int bad   = 0;

   adc_parallel_responder #(.DATA_W(8), .CONV_CYCLES(16)) dut (
      .Clk(Clk), .Rst(Rst), .CONVST(CONVST), .CS(CS), .RD(RD),
      .sample_in(sample_in), .D(D), .D_OE(D_OE), .BUSY(BUSY), .DRDY(DRDY)
`ifdef ADC_RESP_OVERRUN_EN
      , .OVR(OVR)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      int         n;
      logic       convst, cs, rd;
      logic [7:0] smp;
      logic       busy, drdy, doe;
      logic [7:0] d;
      logic       ovr;
   } vec_t;

   vec_t vecs[$];

   task automatic v(input int n, input logic cv, input logic cs, input logic rd,
                    input logic [7:0] s, input logic b, input logic dr, input logic oe,
                    input logic [7:0] d, input logic o);
      vec_t r;
      r.n = n; r.convst = cv; r.cs = cs; r.rd = rd; r.smp = s;
      r.busy = b; r.drdy = dr; r.doe = oe; r.d = d; r.ovr = o;
      vecs.push_back(r);
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: outputs are then sampled and inputs changed half a period away from the edge.
   task automatic step();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   initial begin
      int busy_len;
      int guard;
      string nm;

      //  n  cv cs rd smp    busy drdy oe d      ovr
      // basic conversion of A5 and read
      v(1,  1, 1, 1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      v(1,  0, 1, 1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      v(15, 0, 1, 1, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      v(1,  1, 1, 1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      v(1,  1, 0, 0, 8'h5A, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0);
      v(1,  1, 0, 1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0);
      v(1,  1, 1, 1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0);
      // CS gating in READY
      v(1,  0, 1, 1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0);
      v(15, 1, 1, 1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0);
      v(1,  1, 1, 1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0);
      v(1,  1, 1, 0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0);
      v(1,  1, 1, 1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0);
      v(1,  1, 0, 0, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0);
      v(1,  1, 0, 1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0);
      // sample held at start despite later change
      v(1,  0, 1, 1, 8'h10, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0);
      v(1,  1, 1, 1, 8'h10, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0);
      v(14, 1, 1, 1, 8'hF0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0);
      v(1,  1, 1, 1, 8'hF0, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0);
      v(1,  1, 0, 0, 8'hF0, 1'b0, 1'b1, 1'b1, 8'h10, 1'b0);
      v(1,  1, 0, 1, 8'hF0, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0);
      // second start at BUSY cycle 3 ignored
      v(1,  0, 1, 1, 8'h77, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0);
      v(1,  1, 1, 1, 8'h77, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0);
      v(1,  0, 1, 1, 8'h88, 1'b1, 1'b0, 1'b0, 8'h10, 1'b1);
      v(13, 1, 1, 1, 8'h88, 1'b1, 1'b0, 1'b0, 8'h10, 1'b1);
      v(1,  1, 1, 1, 8'h88, 1'b0, 1'b1, 1'b0, 8'h10, 1'b1);
      v(1,  1, 0, 0, 8'h88, 1'b0, 1'b1, 1'b1, 8'h77, 1'b1);
      v(1,  1, 0, 1, 8'h88, 1'b0, 1'b0, 1'b0, 8'h77, 1'b1);
      // stale read during a conversion started from READY
      v(1,  0, 1, 1, 8'h33, 1'b1, 1'b0, 1'b0, 8'h77, 1'b1);
      v(15, 1, 1, 1, 8'h33, 1'b1, 1'b0, 1'b0, 8'h77, 1'b1);
      v(1,  1, 1, 1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h77, 1'b1);
      v(1,  0, 1, 1, 8'h44, 1'b1, 1'b1, 1'b0, 8'h77, 1'b1);
      v(3,  1, 1, 1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h77, 1'b1);
      v(1,  1, 0, 0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1);
      v(1,  1, 0, 1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h33, 1'b1);
      v(10, 1, 1, 1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h33, 1'b1);
      v(1,  1, 1, 1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h33, 1'b1);
      v(1,  1, 0, 0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h44, 1'b1);
      v(1,  1, 0, 1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h44, 1'b1);

      Rst = 1'b0; CONVST = 1'b1; CS = 1'b1; RD = 1'b1; sample_in = 8'h00;
      repeat (2) step();
      chk("rst_busy", {7'd0, BUSY}, 8'h00);
      chk("rst_drdy", {7'd0, DRDY}, 8'h00);
      chk("rst_doe",  {7'd0, D_OE}, 8'h00);
      chk("rst_d",    D, 8'h00);
      Rst = 1'b1;
      step();

      for (int i = 0; i < vecs.size(); i++) begin
         for (int k = 0; k < vecs[i].n; k++) begin
            CONVST = vecs[i].convst; CS = vecs[i].cs; RD = vecs[i].rd; sample_in = vecs[i].smp;
            step();
            nm = $sformatf("row%0d.%0d", i, k);
            chk({nm, "_busy"}, {7'd0, BUSY}, {7'd0, vecs[i].busy});
            chk({nm, "_drdy"}, {7'd0, DRDY}, {7'd0, vecs[i].drdy});
            chk({nm, "_doe"},  {7'd0, D_OE}, {7'd0, vecs[i].doe});
            chk({nm, "_d"},    D, vecs[i].d);
`ifdef ADC_RESP_OVERRUN_EN
            chk({nm, "_ovr"},  {7'd0, OVR}, {7'd0, vecs[i].ovr});
`endif
         end
      end

      // Reset mid-conversion with cnt at 7.
      CONVST = 1'b1; CS = 1'b1; RD = 1'b1; step();
      CONVST = 1'b0; sample_in = 8'h99; step();
      CONVST = 1'b1;
      repeat (8) step();
      chk("pre_rst_busy", {7'd0, BUSY}, 8'h01);
      #2 Rst = 1'b0;
      #1;
      chk("async_rst_busy", {7'd0, BUSY}, 8'h00);
      step();
      chk("mid_rst_busy", {7'd0, BUSY}, 8'h00);
      chk("mid_rst_drdy", {7'd0, DRDY}, 8'h00);
      chk("mid_rst_doe",  {7'd0, D_OE}, 8'h00);
      chk("mid_rst_d",    D, 8'h00);
`ifdef ADC_RESP_OVERRUN_EN
      chk("mid_rst_ovr",  {7'd0, OVR}, 8'h00);
`endif
      Rst = 1'b1;
      step();

      // Read held active through a whole conversion and its completion.
      CONVST = 1'b0; CS = 1'b0; RD = 1'b0; sample_in = 8'hC3;
      step();
      busy_len = 0;
      guard = 0;
      while (BUSY && guard < 40) begin
         busy_len++;
         chk("read_during_busy_d", D, 8'h00);
         CONVST = 1'b1;
         step();
         guard++;
      end
      chk("busy_timeout", {7'd0, guard < 40}, 8'h01);
      chk("busy_len", 8'(busy_len), 8'd16);
      chk("complete_drdy", {7'd0, DRDY}, 8'h01);
      chk("complete_same_cycle_d", D, 8'h00);
      step();
      chk("complete_next_d", D, 8'hC3);
      chk("complete_next_doe", {7'd0, D_OE}, 8'h01);
      RD = 1'b1;
      step();
      chk("final_drdy", {7'd0, DRDY}, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
